// File: rtl/sort_stream_adapter_if.sv
// Stream-side bundle of the sort stream adapter: input word stream and output word stream.
// The adapter uses the slave modport; the producer/consumer side uses master.
interface sort_stream_adapter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_stream_adapter.sv
// Collects an N-word frame from a stream, kicks the parallel sorter, captures its result
// and streams the sorted words back out with a last flag.
module sort_stream_adapter #(
  parameter int unsigned N       = 6,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sort_stream_adapter_if.slave  strm,
  output logic                  sort_start,
  output logic [WIDTH-1:0]      sort_data   [N],
  input  logic                  sort_done,
  input  logic [WIDTH-1:0]      sort_result [N],
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  localparam int unsigned IdxW = $clog2(N + 1);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [2:0] {StIdle, StLoad, StKick, StWait, StDrain} state_e;

  state_e           state_q, state_d;
  idx_t             wr_idx_q, wr_idx_d;
  idx_t             rd_idx_q, rd_idx_d;
  cnt_t             tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
  logic             load_en;
  logic             capture_en;
  logic [WIDTH-1:0] result_buf_q [N];

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
    load_en    = 1'b0;
    capture_en = 1'b0;

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (strm.in_valid) begin
          load_en  = 1'b1;
          wr_idx_d = wr_idx_q + idx_t'(1);
          if (wr_idx_q == idx_t'(N - 1)) state_d = StKick;
        end
      end
      StKick: begin
        wr_idx_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        // A done arriving on the timeout cycle still wins.
        if (sort_done) begin
          capture_en = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = StDrain;
        end else if (tmo_cnt_q == cnt_t'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + cnt_t'(1);
        end
      end
      StDrain: begin
        if (strm.out_ready) begin
          if (rd_idx_q == idx_t'(N - 1)) begin
            rd_idx_d = '0;
            state_d  = StLoad;
          end else begin
            rd_idx_d = rd_idx_q + idx_t'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        sort_data[i]    <= '0;
        result_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
      // sort_data is only written in LOAD, so it stays frozen while the sorter works.
      if (load_en) sort_data[wr_idx_q] <= strm.in_data;
      if (capture_en) begin
        for (int i = 0; i < int'(N); i++) result_buf_q[i] <= sort_result[i];
      end
    end
  end

  always_comb begin
    strm.in_ready  = (state_q == StLoad);
    strm.out_valid = (state_q == StDrain);
    strm.out_last  = (state_q == StDrain) && (rd_idx_q == idx_t'(N - 1));
    strm.out_data  = (state_q == StDrain) ? result_buf_q[rd_idx_q] : '0;
    sort_start     = (state_q == StKick);
    busy           = (state_q == StKick) || (state_q == StWait) || (state_q == StDrain);
    err_timeout    = err_q;
  end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Directed bench for sort_stream_adapter with a behavioural sorter (real sort, fixed stub
// or silent) driven from the sorter side of the start/done handshake.
module tb_sort_stream_adapter;

  localparam int unsigned N       = 6;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk;
  logic             rst_n;
  logic             sort_start;
  logic [WIDTH-1:0] sort_data   [N];
  logic             sort_done;
  logic [WIDTH-1:0] sort_result [N];
  logic             busy;
  logic             err_timeout;
  logic             err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int sorter_mode = 0;  // 0: real sort, 1: fixed 10..60, 2: never answers

  sort_stream_adapter_if #(.WIDTH(WIDTH)) sif ();

  sort_stream_adapter #(
    .N       (N),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .strm        (sif),
    .sort_start  (sort_start),
    .sort_data   (sort_data),
    .sort_done   (sort_done),
    .sort_result (sort_result),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sort_start) start_cnt++;
    end
  end

  // Sorter model: done lands so the first out_valid is 9 cycles after the last input accept.
  initial begin
    logic [WIDTH-1:0] cap [N];
    logic [WIDTH-1:0] tmp;
    sort_done = 1'b0;
    for (int i = 0; i < int'(N); i++) sort_result[i] = '0;
    forever begin
      @(negedge clk);
      if (sort_start && sorter_mode != 2) begin
        cap = sort_data;
        repeat (8) @(negedge clk);
        for (int i = 0; i < int'(N); i++) check("sort_data_stable", int'(sort_data[i]), int'(cap[i]));
        if (sorter_mode == 0) begin
          for (int a = 0; a < int'(N) - 1; a++)
            for (int b = 0; b < int'(N) - 1 - a; b++)
              if (cap[b] > cap[b+1]) begin
                tmp = cap[b]; cap[b] = cap[b+1]; cap[b+1] = tmp;
              end
          sort_result = cap;
        end else begin
          for (int i = 0; i < int'(N); i++) sort_result[i] = WIDTH'(10 * (i + 1));
        end
        sort_done = 1'b1;
        @(negedge clk);
        sort_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] w);
    int budget = 50;
    sif.in_valid = 1'b1;
    sif.in_data  = w;
    while (!sif.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("in_ready_wait", int'(sif.in_ready), 1);
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w [N], input bit gaps);
    for (int i = 0; i < int'(N); i++) begin
      push(w[i]);
      if (gaps && i < int'(N) - 1) begin
        check("no_early_start", int'(sort_start), 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic collect(input logic [WIDTH-1:0] exp [N], input int n_words,
                         input int stall_idx, input int stall_len, output int lat);
    lat = 0;
    while (!sif.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_wait", int'(sif.out_valid), 1);
    for (int i = 0; i < n_words; i++) begin
      check("out_data", int'(sif.out_data), int'(exp[i]));
      check("out_last", int'(sif.out_last), (i == int'(N) - 1) ? 1 : 0);
      check("busy_drain", int'(busy), 1);
      if (i == stall_idx) begin
        sif.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_data", int'(sif.out_data), int'(exp[i]));
          check("stall_valid", int'(sif.out_valid), 1);
        end
      end
      sif.out_ready = 1'b1;
      @(negedge clk);
      sif.out_ready = 1'b0;
    end
    if (n_words == int'(N)) begin
      check("post_out_valid", int'(sif.out_valid), 0);
      check("post_in_ready", int'(sif.in_ready), 1);
      check("post_busy", int'(busy), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(sif.in_ready), 0);
    check({tag, "_out_valid"}, int'(sif.out_valid), 0);
    check({tag, "_out_last"}, int'(sif.out_last), 0);
    check({tag, "_out_data"}, int'(sif.out_data), 0);
    check({tag, "_sort_start"}, int'(sort_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err_timeout), 0);
    for (int i = 0; i < int'(N); i++) check({tag, "_sort_data"}, int'(sort_data[i]), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] f_a [N];
    logic [WIDTH-1:0] e_a [N];
    logic [WIDTH-1:0] f_b [N];
    logic [WIDTH-1:0] e_b [N];
    int lat;
    int s0;

    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    err_clr       = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic frame, in_valid held high
    sorter_mode = 0;
    f_a = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    e_a = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9};
    s0 = start_cnt;
    push_frame(f_a, 1'b0);
    check("kick_start", int'(sort_start), 1);
    check("kick_busy", int'(busy), 1);
    check("kick_in_ready", int'(sif.in_ready), 0);
    collect(e_a, N, -1, 0, lat);
    check("latency", lat, 9);
    check("start_pulses", start_cnt - s0, 1);

    // Same words with gaps in in_valid
    s0 = start_cnt;
    push_frame(f_a, 1'b1);
    check("gap_start", int'(sort_start), 1);
    for (int i = 0; i < int'(N); i++) check("gap_sort_data", int'(sort_data[i]), int'(f_a[i]));
    collect(e_a, N, -1, 0, lat);
    check("gap_start_pulses", start_cnt - s0, 1);

    // Backpressure against fixed stub result
    sorter_mode = 1;
    f_b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    e_b = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    push_frame(f_b, 1'b0);
    collect(e_b, N, 1, 3, lat);

    // Timeout: sorter never answers
    sorter_mode = 2;
    push_frame(f_b, 1'b0);
    lat = 0;
    while (!err_timeout && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_cycles", lat, int'(TIMEOUT) + 1);
    check("timeout_in_ready_idle", int'(sif.in_ready), 0);
    check("timeout_busy", int'(busy), 0);
    @(negedge clk);
    check("timeout_in_ready_load", int'(sif.in_ready), 1);
    check("timeout_err_sticky", int'(err_timeout), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", int'(err_timeout), 0);

    // Back-to-back frames
    sorter_mode = 0;
    f_a = '{8'd4, 8'd4, 8'd4, 8'd1, 8'd1, 8'd0};
    e_a = '{8'd0, 8'd1, 8'd1, 8'd4, 8'd4, 8'd4};
    f_b = '{8'd255, 8'd0, 8'd128, 8'd1, 8'd2, 8'd3};
    e_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd128, 8'd255};
    push_frame(f_a, 1'b0);
    collect(e_a, N, -1, 0, lat);
    push_frame(f_b, 1'b0);
    collect(e_b, N, -1, 0, lat);

    // Reset in the middle of DRAIN
    f_a = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
    e_a = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    push_frame(f_a, 1'b0);
    collect(e_a, 2, -1, 0, lat);
    check("pre_reset_out_valid", int'(sif.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    f_b = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e_b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    push_frame(f_b, 1'b0);
    collect(e_b, N, -1, 0, lat);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
